// File: rtl/fifo_drain_pkg.sv
// Shared definitions for the FIFO serial drain.
// Holds the drain FSM state type and the default width / bit-period values.
package fifo_drain_pkg;

  localparam int unsigned DefaultWidth      = 8;
  localparam int unsigned DefaultClksPerBit = 4;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StStart,
    StData,
    StStop
  } drain_state_t;

endpackage

// File: rtl/bit_timer.sv
// Free-running bit-period counter for the serial drain.
// Ports:
//   clk   - system clock
//   rst   - asynchronous active-high reset
//   clear - synchronously restarts the count at 0 on the next edge
//   tick  - high while the count is CLKS_PER_BIT-1 (last cycle of a bit)
module bit_timer
  import fifo_drain_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || (cnt_q == CntMax)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == CntMax);

endmodule

// File: rtl/fifo_serial_drain.sv
// Read-side consumer of a synchronous FIFO: pops one word whenever idle and the
// FIFO is non-empty, then sends it LSB-first as a start bit, WIDTH data bits
// and a stop bit, each CLKS_PER_BIT clocks long.
// Ports:
//   clk        - system clock
//   rst        - asynchronous active-high reset
//   empty      - FIFO empty flag
//   fifo_data  - FIFO read data, valid the cycle after rd
//   rd         - FIFO read strobe, one cycle per word
//   tx         - registered serial line, idles high
//   busy       - high in every state except idle
//   frame_done - pulse in the last cycle of each stop bit
module fifo_serial_drain
  import fifo_drain_pkg::*;
#(
  parameter int unsigned WIDTH        = DefaultWidth,
  parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             rd,
  output logic             tx,
  output logic             busy,
  output logic             frame_done
);

  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(WIDTH - 1);

  drain_state_t     state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             tx_q, tx_d;
  logic             timer_clear;
  logic             tick;

  // Restarting the timer in FETCH lines the first START cycle up with count 0.
  assign timer_clear = (state_q == StFetch);

  bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (timer_clear),
    .tick  (tick)
  );

  // tx_d is the line level for the state being entered, so tx stays registered
  // yet changes in the first cycle of each bit.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (!empty) begin
          state_d = StFetch;
        end
      end
      StFetch: begin
        shift_d = fifo_data;
        idx_d   = '0;
        tx_d    = 1'b0;
        state_d = StStart;
      end
      StStart: begin
        if (tick) begin
          idx_d   = '0;
          tx_d    = shift_q[0];
          state_d = StData;
        end
      end
      StData: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 1'b1;
          if (idx_q == IdxLast) begin
            tx_d    = 1'b1;
            state_d = StStop;
          end else begin
            tx_d = shift_d[0];
          end
        end
      end
      StStop: begin
        if (tick) begin
          tx_d    = 1'b1;
          state_d = StIdle;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
    end
  end

  // rd is gated by rst so a non-empty FIFO is never popped while held in reset.
  assign rd         = (state_q == StIdle) && !empty && !rst;
  assign tx         = tx_q;
  assign busy       = (state_q != StIdle);
  assign frame_done = (state_q == StStop) && tick;

endmodule

// File: tb/tb_fifo_serial_drain.sv
module tb_fifo_serial_drain;

  localparam int unsigned W      = 8;
  localparam int unsigned Cpb    = 4;
  localparam int unsigned Depth  = 16;
  localparam int          FrameN = (W + 2) * Cpb;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         empty;
  logic [W-1:0] fifo_data;
  logic         rd, tx, busy, frame_done;
  logic         wr = 1'b0;
  logic [W-1:0] wdata = '0;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  fifo_serial_drain #(
    .WIDTH        (W),
    .CLKS_PER_BIT (Cpb)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .empty      (empty),
    .fifo_data  (fifo_data),
    .rd         (rd),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural FIFO (DEPTH 16); rd is taken from the mid-cycle sample rd_s.
  logic [W-1:0] fmem [Depth];
  int           fcount = 0;
  int           frd = 0;
  int           fwr = 0;
  logic         rd_s = 1'b0;

  assign empty = (fcount == 0);

  always @(posedge clk) begin : fifo_blk
    bit do_rd, do_wr;
    do_rd = rd_s && (fcount > 0);
    do_wr = wr && ((fcount < Depth) || do_rd);
    if (do_rd) begin
      fifo_data <= fmem[frd];
      frd       <= (frd + 1) % Depth;
    end
    if (do_wr) begin
      fmem[fwr] <= wdata;
      fwr       <= (fwr + 1) % Depth;
    end
    fcount <= fcount + int'(do_wr) - int'(do_rd);
  end

  // Scoreboard and serial-line monitor.
  logic [W-1:0] exp_q[$];
  int           rd_log[$];
  int           rd_count  = 0;
  int           frames    = 0;
  int           start_cyc = 0;
  int           done_cyc  = 0;
  bit           in_frame  = 1'b0;
  int           mcnt      = 0;
  logic [W-1:0] rx = '0;

  always @(negedge clk) begin : mon
    logic [W-1:0] exp_w;
    int slot;
    rd_s = (rd === 1'b1);
    if (rd === 1'b1) begin
      rd_count++;
      rd_log.push_back(cyc);
      n_cmp++;
      if (empty !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL rd_guard: cycle %0d empty=%b busy=%b, required empty=0 busy=0",
                 cyc, empty, busy);
      end
    end
    if (rst === 1'b1) begin
      in_frame = 1'b0;
    end else if (!in_frame) begin
      if (tx === 1'b0) begin
        in_frame  = 1'b1;
        mcnt      = 0;
        start_cyc = cyc;
      end
    end else begin
      mcnt++;
    end
    if (frame_done === 1'b1) begin
      n_cmp++;
      if (!(in_frame && mcnt == FrameN - 1)) begin
        n_err++;
        $display("FAIL frame_done_timing: pulse at frame offset %0d (in_frame=%0b), required %0d",
                 mcnt, in_frame, FrameN - 1);
      end
    end
    if (in_frame) begin
      slot = mcnt / Cpb;
      if (mcnt % Cpb == Cpb / 2) begin
        if (slot == 0 && tx !== 1'b0) begin
          n_cmp++; n_err++;
          $display("FAIL start_bit: tx=%b mid start bit, required 0", tx);
        end else if (slot >= 1 && slot <= W) begin
          rx[slot-1] = tx;
        end else if (slot == W + 1) begin
          n_cmp++;
          if (tx !== 1'b1) begin
            n_err++;
            $display("FAIL stop_bit: tx=%b mid stop bit, required 1", tx);
          end
        end
      end
      if (mcnt == FrameN - 1) begin
        in_frame = 1'b0;
        frames++;
        done_cyc = cyc;
        n_cmp++;
        if (frame_done !== 1'b1) begin
          n_err++;
          $display("FAIL frame_done_missing: frame_done=%b in last stop cycle, required 1",
                   frame_done);
        end
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL frame_data: decoded 0x%02h with no word outstanding", rx);
        end else begin
          exp_w = exp_q.pop_front();
          if (rx !== exp_w) begin
            n_err++;
            $display("FAIL frame_data: decoded 0x%02h, required 0x%02h", rx, exp_w);
          end
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic write_word(input logic [W-1:0] v);
    wr    = 1'b1;
    wdata = v;
    exp_q.push_back(v);
    step();
    wr = 1'b0;
  endtask

  task automatic wait_drain(input int max, output bit ok);
    int i = 0;
    while ((exp_q.size() != 0 || fcount != 0 || busy !== 1'b0 || in_frame) && i < max) begin
      step();
      i++;
    end
    ok = (i < max);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++;
      if (tx !== 1'b1 || rd !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hold: tx=%b rd=%b busy=%b, required 1/0/0", tx, rd, busy);
      end
    end
    release_reset();
    for (int i = 0; i < 20; i++) begin
      step();
      n_cmp++;
      if (tx !== 1'b1 || rd !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
        n_err++;
        $display("FAIL reset_idle: cycle %0d tx=%b rd=%b busy=%b fd=%b, required 1/0/0/0",
                 i, tx, rd, busy, frame_done);
      end
    end
  endtask

  task automatic test_single();
    int base_rd = rd_count;
    int base_fr = frames;
    bit ok;
    rd_log.delete();
    write_word(8'hA5);
    wait_drain(200, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL single_timeout: frame not drained, required drain"); end
    n_cmp++;
    if (rd_count - base_rd != 1 || frames - base_fr != 1) begin
      n_err++;
      $display("FAIL single_count: rd=%0d frames=%0d, required 1/1",
               rd_count - base_rd, frames - base_fr);
    end
    n_cmp++;
    if (rd_log.size() < 1 || start_cyc - rd_log[0] != 2) begin
      n_err++;
      $display("FAIL single_latency: rd->start %0d cycles, required 2",
               (rd_log.size() > 0) ? start_cyc - rd_log[0] : -1);
    end
    n_cmp++;
    if (done_cyc - start_cyc != FrameN - 1) begin
      n_err++;
      $display("FAIL single_length: start->done %0d, required %0d", done_cyc - start_cyc,
               FrameN - 1);
    end
  endtask

  task automatic test_burst();
    int base_rd = rd_count;
    int base_fr = frames;
    int i = 0;
    bit ok;
    rd_log.delete();
    write_word(8'h00);
    write_word(8'hFF);
    write_word(8'h3C);
    while (rd_count < base_rd + 3 && i < 300) begin step(); i++; end
    step();
    n_cmp++;
    if (i >= 300 || empty !== 1'b1) begin
      n_err++;
      $display("FAIL burst_empty: empty=%b after third rd (waited %0d), required 1", empty, i);
    end
    wait_drain(300, ok);
    n_cmp++;
    if (!ok || frames - base_fr != 3) begin
      n_err++;
      $display("FAIL burst_frames: frames=%0d ok=%0b, required 3", frames - base_fr, ok);
    end
    n_cmp++;
    if (rd_log.size() != 3 || rd_log[1] - rd_log[0] != 42 || rd_log[2] - rd_log[1] != 42) begin
      n_err++;
      $display("FAIL burst_spacing: %0d rd pulses, required 3 spaced 42 cycles", rd_log.size());
    end
  endtask

  task automatic test_fill();
    int base_rd = rd_count;
    int base_fr = frames;
    bit ok;
    for (int v = 1; v <= 16; v++) write_word(W'(v));
    wait_drain(16 * 42 + 100, ok);
    n_cmp++;
    if (!ok || frames - base_fr != 16 || rd_count - base_rd != 16) begin
      n_err++;
      $display("FAIL fill_count: frames=%0d rd=%0d ok=%0b, required 16/16/1",
               frames - base_fr, rd_count - base_rd, ok);
    end
  endtask

  task automatic test_reset_mid();
    int i = 0;
    int base_rd;
    int base_fr;
    bit ok;
    logic [W-1:0] dropped;
    write_word(8'h5A);
    write_word(8'h33);
    while (!(in_frame && mcnt == 17) && i < 200) begin step(); i++; end
    n_cmp++;
    if (i >= 200) begin n_err++; $display("FAIL midrst_reach: data bit 3 not reached"); end
    rst = 1'b1;
    dropped = exp_q.pop_front();
    #1;
    n_cmp++;
    if (tx !== 1'b1 || busy !== 1'b0 || rd !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_async: tx=%b busy=%b rd=%b, required 1/0/0", tx, busy, rd);
    end
    step();
    n_cmp++;
    if (tx !== 1'b1 || rd !== 1'b0 || empty !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_hold: tx=%b rd=%b empty=%b, required 1/0/0 (0x%02h dropped)",
               tx, rd, empty, dropped);
    end
    base_rd = rd_count;
    base_fr = frames;
    release_reset();
    wait_drain(200, ok);
    n_cmp++;
    if (!ok || frames - base_fr != 1 || rd_count - base_rd != 1) begin
      n_err++;
      $display("FAIL midrst_resume: frames=%0d rd=%0d ok=%0b, required 1/1/1",
               frames - base_fr, rd_count - base_rd, ok);
    end
  endtask

  task automatic test_empty_flicker();
    int i = 0;
    int base_fr = frames;
    int d1;
    bit ok;
    rd_log.delete();
    write_word(8'hC3);
    while (!(in_frame && mcnt == 37) && i < 200) begin step(); i++; end
    write_word(8'h96);
    i = 0;
    while (frames < base_fr + 1 && i < 100) begin step(); i++; end
    d1 = done_cyc;
    wait_drain(200, ok);
    n_cmp++;
    if (!ok || frames - base_fr != 2 || rd_log.size() != 2) begin
      n_err++;
      $display("FAIL flicker_count: frames=%0d rd=%0d ok=%0b, required 2/2/1",
               frames - base_fr, rd_log.size(), ok);
    end
    n_cmp++;
    if (rd_log.size() != 2 || rd_log[1] - rd_log[0] != 42) begin
      n_err++;
      $display("FAIL flicker_rd: second rd not 42 cycles after first (%0d pulses)",
               rd_log.size());
    end
    n_cmp++;
    if (start_cyc - d1 != 3) begin
      n_err++;
      $display("FAIL flicker_gap: done->next start %0d cycles, required 3", start_cyc - d1);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_fill();
    test_reset_mid();
    test_empty_flicker();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
